alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter sharing a single `sync_alu` instance among NUM_REQ requesters. Each requester issues an operation over a valid/ready handshake, and results are returned through a per-requester response slot with its own valid/ready handshake. The block sits between the processing units and the one registered ALU, and owns that ALU instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DW, `DATA_WIDTH: operand and result width.
- OPW, `ALU_OP_WIDTH: opcode width.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*DW  operand A; requester i in bits [i*DW +: DW].
- req_b  in  NUM_REQ*DW  operand B; same packing as req_a.
- req_op  in  NUM_REQ*OPW  ALU opcode; requester i in bits [i*OPW +: OPW].
- rsp_valid  out  NUM_REQ  response slot i holds a result.
- rsp_ready  in  NUM_REQ  requester i consumes its response.
- rsp_data  out  NUM_REQ*DW  result of slot i.
- rsp_ovf  out  NUM_REQ  overflow flag of slot i.
- busy  out  1  an ALU operation is in flight.
- op_count  out  32  number of completed operations; wraps at 2^32.

## Operation
**Eligibility**
- Requester i is eligible when all of the following hold:
  - req_valid[i] = 1.
  - Slot i is empty.
  - No in-flight operation is tagged i.

**Arbitration**
- Each cycle, the block searches for an eligible requester starting at pointer ptr, then ptr+1, and so on, modulo NUM_REQ.
- The first eligible requester k is granted: req_ready[k] = 1, and all other req_ready bits are 0.
- req_ready is combinational from req_valid and registered state only. It never depends on req_a, req_b or req_op.
- Requesters must not make req_valid depend on req_ready.
- On a grant, ptr <= (k+1) mod NUM_REQ.
- With no grant, ptr holds its value.

**Issue**
- The granted requester's A, B and op are muxed into the ALU.
- When nothing is granted, the ALU inputs are zero and the op is the zero opcode. The ALU result is ignored in that case.
- On a grant, the in-flight register captures infl_v <= 1 and infl_id <= k. With no grant, infl_v <= 0.

**Completion**
- When infl_v = 1, slot[infl_id] captures the ALU output (Z and overflow) and is marked full.
- op_count increments by 1 at the same time.

**Response**
- rsp_valid[i] reflects the full flag of slot i.
- Slot i is cleared when rsp_valid[i] && rsp_ready[i].
- A completion write and a clear never target the same slot in the same cycle, because of the eligibility rule. Implementation may assert this.
- rsp_data and rsp_ovf for a slot hold their last value after the slot is cleared.

**Other outputs**
- busy = infl_v.

**Reset values**
- req_ready = 0 while rst_n is low (combinational, because all slots read as empty... gated by reset).
- rsp_valid = 0, rsp_data = 0, rsp_ovf = 0.
- busy = 0, op_count = 0, ptr = 0.
- Internal ALU output = 0.
- Reset mid-operation discards the in-flight op and all held responses. No response is produced for them.

## Timing
**Single operation**
- Request accepted at the end of cycle t (req_valid && req_ready).
- ALU register captures at the end of cycle t.
- Slot captures the result at the end of cycle t+1.
- rsp_valid is high from cycle t+2.
- Accept-to-response latency is 2 cycles.

**Throughput**
- Different requesters can be granted on consecutive cycles, one op per cycle.
- The same requester cannot be granted again until the cycle after its response is consumed.
- Minimum same-requester reissue interval is 3 cycles, with rsp_ready held high.

**Simultaneous events**
- If all requesters are valid, grants rotate 0,1,2,3,0,... from reset.
- A requester whose slot is full is skipped without stalling the others. ptr advances past the requester that was granted, not past the skipped one.
- rsp_ready on an empty slot has no effect.
- Completion and a consume on different slots in the same cycle are both honoured.

## Test plan
- **Single op.** After reset, req0 ADD A=5, B=7 at cycle 2 → req_ready[0]=1 at cycle 2; rsp_valid[0]=1 and rsp_data[0]=12 at cycle 4; op_count=1.
- **All requesters contend.** All 4 valid continuously with distinct operands, rsp_ready=4'hF → grants in order 0,1,2,3 on consecutive cycles; responses return in the same order, each 2 cycles after its grant; then req0 is granted again.
- **Slot-full backpressure.** req1 completes with rsp_ready[1]=0 while req1 stays valid → req1 is never granted and req2 is granted normally; raising rsp_ready[1] for one cycle → req1 is re-granted the following cycle.
- **Overflow.** Signed ADD of 0x7FFF_FFFF + 1 (DW=32) → rsp_ovf=1 and rsp_data=0x8000_0000 for that slot; next op without overflow gives rsp_ovf=0.
- **Reset mid-flight.** Assert rst_n low in the cycle after a grant → all rsp_valid, busy and op_count read 0; after release, no stale response appears and the next grant starts from requester 0.
- **op_count wrap.** Force op_count to 0xFFFF_FFFF and complete one op → op_count=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: operation request and per-requester
// response slots, each with its own valid/ready handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = `DATA_WIDTH,
  parameter int unsigned OPW     = `ALU_OP_WIDTH
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*DW-1:0]  req_a;
  logic [NUM_REQ*DW-1:0]  req_b;
  logic [NUM_REQ*OPW-1:0] req_op;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [NUM_REQ*DW-1:0]  rsp_data;
  logic [NUM_REQ-1:0]     rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU (sync_alu) among NUM_REQ
// requesters. Results land in per-requester response slots.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

// Registered ALU: result and signed-overflow flag appear one cycle after
// the operands. Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL,
// 7 SLT (signed); any other opcode yields zero.
module sync_alu #(
  parameter int unsigned DW  = `DATA_WIDTH,
  parameter int unsigned OPW = `ALU_OP_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  z,
  output logic           ovf
);
  localparam int unsigned SHW = $clog2(DW);
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL = OPW'(6);
  localparam logic [OPW-1:0] OP_SLT = OPW'(7);

  logic [DW-1:0] sum, diff, z_d, z_q;
  logic          ovf_d, ovf_q;

  // Operation decode and signed-overflow detection.
  always_comb begin
    sum   = a + b;
    diff  = a - b;
    z_d   = '0;
    ovf_d = 1'b0;
    case (op)
      OP_ADD: begin
        z_d   = sum;
        ovf_d = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        z_d   = diff;
        ovf_d = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND:  z_d = a & b;
      OP_OR:   z_d = a | b;
      OP_XOR:  z_d = a ^ b;
      OP_SLL:  z_d = a << b[SHW-1:0];
      OP_SRL:  z_d = a >> b[SHW-1:0];
      OP_SLT:  z_d = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: z_d = '0;
    endcase
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      ovf_q <= ovf_d;
    end
  end

  assign z   = z_q;
  assign ovf = ovf_q;
endmodule

module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = `DATA_WIDTH,
  parameter int unsigned OPW     = `ALU_OP_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic              busy,
  output logic [31:0]       op_count
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]               ptr_q, ptr_d;
  logic                         infl_v_q, infl_v_d;
  logic [IDW-1:0]               infl_id_q, infl_id_d;
  logic [NUM_REQ-1:0]           full_q, full_d;
  logic [NUM_REQ-1:0][DW-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]           ovf_q, ovf_d;
  logic [31:0]                  op_count_q, op_count_d;

  logic [NUM_REQ-1:0]           elig;
  logic [NUM_REQ-1:0]           ready_c;
  logic                         grant_vld;
  logic [IDW-1:0]               grant_id;
  logic [IDW:0]                 scan;
  logic [IDW-1:0]               idx;
  logic [DW-1:0]                alu_a, alu_b, alu_z;
  logic [OPW-1:0]               alu_op;
  logic                         alu_ovf;

  // A requester may issue only when its slot is empty and nothing of its own is in flight.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && !full_q[i] &&
                !(infl_v_q && (infl_id_q == IDW'(i)));
    end
  end

  // Round-robin search from ptr; the index wraps modulo NUM_REQ, which need not be a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    idx       = '0;
    ready_c   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(j);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      idx = scan[IDW-1:0];
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    if (grant_vld && rst_n) ready_c[grant_id] = 1'b1;
  end

  // Granted operands drive the ALU; idle cycles present zeros.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (grant_vld) begin
      alu_a  = bus.req_a[grant_id*DW +: DW];
      alu_b  = bus.req_b[grant_id*DW +: DW];
      alu_op = bus.req_op[grant_id*OPW +: OPW];
    end
  end

  sync_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .z     (alu_z),
    .ovf   (alu_ovf)
  );

  // Next state: slot consume, completion write, in-flight tag and pointer advance.
  always_comb begin
    ptr_d      = ptr_q;
    infl_v_d   = grant_vld;
    infl_id_d  = grant_id;
    full_d     = full_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    op_count_d = op_count_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (full_q[i] && bus.rsp_ready[i]) full_d[i] = 1'b0;
    end
    if (infl_v_q) begin
      full_d[infl_id_q] = 1'b1;
      data_d[infl_id_q] = alu_z;
      ovf_d[infl_id_q]  = alu_ovf;
      op_count_d        = op_count_q + 32'd1;
    end
    if (grant_vld) begin
      ptr_d = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // State registers; reset drops any in-flight op and held responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      infl_v_q   <= 1'b0;
      infl_id_q  <= '0;
      full_q     <= '0;
      data_q     <= '0;
      ovf_q      <= '0;
      op_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      infl_v_q   <= infl_v_d;
      infl_id_q  <= infl_id_d;
      full_q     <= full_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = full_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_ovf   = ovf_q;
  assign busy          = infl_v_q;
  assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_alu_arbiter;
  localparam int N = 4;
  localparam logic [3:0] ADD = 4'd0;

  logic        clk, rst_n, busy;
  logic [31:0] op_count;

  alu_arbiter_if #(.NUM_REQ(N), .DW(32), .OPW(4)) bus ();

  alu_arbiter #(.NUM_REQ(N), .DW(32), .OPW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_infl_v;
  int          m_infl_id;
  logic [31:0] m_pend_z;
  logic        m_pend_ovf;
  logic [3:0]  m_full;
  logic [31:0] m_data [N];
  logic [3:0]  m_ovf;
  logic [31:0] m_count;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, output logic [31:0] z, output logic o);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    z  = 32'd0;
    o  = 1'b0;
    case (op)
      4'd0: begin r = sa + sb; z = r[31:0]; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd1: begin r = sa - sb; z = r[31:0]; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd2: z = a & b;
      4'd3: z = a | b;
      4'd4: z = a ^ b;
      4'd5: z = a << (b % 32);
      4'd6: z = a >> (b % 32);
      4'd7: z = (sa < sb) ? 32'd1 : 32'd0;
      default: z = 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_infl_v = 0; m_infl_id = 0; m_pend_z = '0; m_pend_ovf = 0;
    m_full = '0; m_ovf = '0; m_count = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
  endtask

  function automatic int model_grant();
    for (int j = 0; j < N; j++) begin
      int k;
      k = (m_ptr + j) % N;
      if (bus.req_valid[k] && !m_full[k] && !(m_infl_v && m_infl_id == k)) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    bus.req_valid[i]      = v;
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_op[i*4 +: 4]  = op;
  endtask

  task automatic check_all();
    int g;
    logic [3:0]   er;
    logic [127:0] ed;
    g  = model_grant();
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    for (int i = 0; i < N; i++) ed[i*32 +: 32] = m_data[i];
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, m_full);
    chk("rsp_data",  bus.rsp_data,  ed);
    chk("rsp_ovf",   bus.rsp_ovf,   m_ovf);
    chk("busy",      busy,          m_infl_v);
    chk("op_count",  op_count,      m_count);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    int g;
    logic [31:0] z;
    logic        o;
    #1 check_all();
    g = model_grant();
    @(posedge clk);
    for (int i = 0; i < N; i++) if (m_full[i] && bus.rsp_ready[i]) m_full[i] = 1'b0;
    if (m_infl_v) begin
      m_full[m_infl_id] = 1'b1;
      m_data[m_infl_id] = m_pend_z;
      m_ovf[m_infl_id]  = m_pend_ovf;
      m_count           = m_count + 32'd1;
    end
    if (g >= 0) begin
      ref_alu(bus.req_a[g*32 +: 32], bus.req_b[g*32 +: 32], bus.req_op[g*4 +: 4], z, o);
      m_pend_z = z; m_pend_ovf = o; m_infl_v = 1; m_infl_id = g; m_ptr = (g + 1) % N;
    end else begin
      m_infl_v = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("rst_rsp_data",  bus.rsp_data,  128'd0);
    chk("rst_rsp_ovf",   bus.rsp_ovf,   4'b0000);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_op_count",  op_count,      32'd0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_all(input logic [3:0] rr);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, ADD);
    bus.rsp_ready = rr;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.rsp_ready = '0;
    @(negedge clk);
    do_reset(2);

    // Single op: ADD 5+7 on requester 0
    idle_all(4'b0000);
    cycle(); cycle();
    set_req(0, 1'b1, 32'd5, 32'd7, ADD);
    #1 chk("single_grant", bus.req_ready, 4'b0001);
    cycle();
    set_req(0, 1'b0, '0, '0, ADD);
    cycle();
    #1;
    chk("single_rsp_valid", bus.rsp_valid[0], 1'b1);
    chk("single_rsp_data",  bus.rsp_data[31:0], 32'd12);
    chk("single_op_count",  op_count, 32'd1);
    bus.rsp_ready = 4'b1111;
    cycle(); cycle();

    // All requesters contend from reset
    do_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(100 + i), 32'(i * 3), 4'(i));
    bus.rsp_ready = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1 chk("rr_order", bus.req_ready, 4'b0001 << (c % 4));
      cycle();
    end

    // Slot-full backpressure on requester 1
    do_reset(1);
    idle_all(4'b1101);
    set_req(1, 1'b1, 32'd11, 32'd22, ADD);
    set_req(2, 1'b1, 32'd33, 32'd44, 4'd1);
    cycle(); cycle();
    for (int c = 0; c < 7; c++) begin
      #1 chk("bp_req1_blocked", bus.req_ready[1], 1'b0);
      cycle();
    end
    bus.rsp_ready = 4'b1111;
    cycle();
    bus.rsp_ready = 4'b1101;
    #1 chk("bp_req1_regrant", bus.req_ready, 4'b0010);
    cycle(); cycle(); cycle();

    // Overflow then no overflow on requester 3
    idle_all(4'b1111);
    cycle(); cycle(); cycle();
    set_req(3, 1'b1, 32'h7FFF_FFFF, 32'd1, ADD);
    cycle();
    set_req(3, 1'b0, '0, '0, ADD);
    cycle();
    #1;
    chk("ovf_flag", bus.rsp_ovf[3], 1'b1);
    chk("ovf_data", bus.rsp_data[127:96], 32'h8000_0000);
    cycle();
    set_req(3, 1'b1, 32'd1, 32'd2, ADD);
    cycle();
    set_req(3, 1'b0, '0, '0, ADD);
    cycle();
    #1;
    chk("noovf_flag", bus.rsp_ovf[3], 1'b0);
    chk("noovf_data", bus.rsp_data[127:96], 32'd3);
    cycle();

    // Reset in the cycle after a grant
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i), 32'(i), ADD);
    cycle();
    do_reset(2);
    #1 chk("post_reset_grant", bus.req_ready, 4'b0001);
    for (int c = 0; c < 6; c++) cycle();

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom_range(0, 9)));
      bus.rsp_ready = 4'($urandom);
      cycle();
    end

    // op_count wrap
    idle_all(4'b1111);
    cycle(); cycle(); cycle();
    force dut.op_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.op_count_q;
    m_count = 32'hFFFF_FFFF;
    #1 chk("wrap_preset", op_count, 32'hFFFF_FFFF);
    set_req(2, 1'b1, 32'd3, 32'd4, ADD);
    cycle();
    set_req(2, 1'b0, '0, '0, ADD);
    cycle();
    #1 chk("wrap_zero", op_count, 32'd0);
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
